// File: rtl/player_life_ctrl.sv
// Game-level sequencer for the player: qualifies hits, counts lives and levels,
// freezes movement while dying and times the respawn and immunity windows in frames.
module player_life_ctrl #(
   parameter int INITIAL_LIVES  = 3,
   parameter int MAX_LIVES      = 7,
   parameter int RESPAWN_FRAMES = 256,
   parameter int INVULN_FRAMES  = 64
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       startGame,
   input  logic       playerCollision,
   input  logic       levelCleared,
   output logic       hitOut,
   output logic       freezeMove,
   output logic       respawnReq,
   output logic       invulnerable,
   output logic [2:0] lives,
   output logic [3:0] level,
   output logic [1:0] gameState,
   output logic [1:0] deathPhase
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_PLAY      = 2'b01,
      S_DYING     = 2'b10,
      S_GAME_OVER = 2'b11
   } state_t;

   localparam logic [2:0] INIT_LIVES = 3'(INITIAL_LIVES);
   localparam logic [2:0] LIVES_CAP  = 3'(MAX_LIVES);
   localparam logic [8:0] RESP_LAST  = 9'(RESPAWN_FRAMES - 1);
   localparam logic [8:0] INV_LOAD   = 9'(INVULN_FRAMES);

   state_t     state_q, state_d;
   logic [2:0] lives_q, lives_d;
   logic [3:0] level_q, level_d;
   logic [8:0] death_cnt_q, death_cnt_d;
   logic [8:0] invuln_cnt_q, invuln_cnt_d;
   logic       respawn_req_q, respawn_req_d;

   logic       qual_hit;
   logic       start_load;
   logic       respawn_now;

   // Immunity is judged on the current count, so a hit on the frame that
   // drops the count from 1 to 0 is still ignored.
   assign qual_hit    = playerCollision && (state_q == S_PLAY) && (invuln_cnt_q == 9'd0);
   assign start_load  = startGame && ((state_q == S_IDLE) || (state_q == S_GAME_OVER));
   assign respawn_now = (state_q == S_DYING) && startOfFrame && (death_cnt_q == RESP_LAST);

   // State register and datapath flops
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= S_IDLE;
         lives_q       <= INIT_LIVES;
         level_q       <= 4'd0;
         death_cnt_q   <= 9'd0;
         invuln_cnt_q  <= 9'd0;
         respawn_req_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         level_q       <= level_d;
         death_cnt_q   <= death_cnt_d;
         invuln_cnt_q  <= invuln_cnt_d;
         respawn_req_q <= respawn_req_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start_load) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (qual_hit) state_d = (lives_q == 3'd1) ? S_GAME_OVER : S_DYING;
         end
         S_DYING: begin
            if (respawn_now) state_d = S_PLAY;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counters, lives and level
   always_comb begin
      lives_d       = lives_q;
      level_d       = level_q;
      death_cnt_d   = death_cnt_q;
      invuln_cnt_d  = invuln_cnt_q;
      respawn_req_d = 1'b0;
      if (start_load) begin
         lives_d       = INIT_LIVES;
         level_d       = 4'd0;
         death_cnt_d   = 9'd0;
         invuln_cnt_d  = INV_LOAD;
         respawn_req_d = 1'b1;
      end else if (state_q == S_PLAY) begin
         if (qual_hit) begin
            // A hit swallows any same-cycle frame tick and level clear.
            lives_d     = lives_q - 3'd1;
            death_cnt_d = 9'd0;
         end else begin
            if (startOfFrame && (invuln_cnt_q != 9'd0)) invuln_cnt_d = invuln_cnt_q - 9'd1;
            if (levelCleared) begin
               level_d = level_q + 4'd1;
               lives_d = (lives_q >= LIVES_CAP) ? LIVES_CAP : lives_q + 3'd1;
            end
         end
      end else if ((state_q == S_DYING) && startOfFrame) begin
         if (respawn_now) begin
            death_cnt_d   = 9'd0;
            invuln_cnt_d  = INV_LOAD;
            respawn_req_d = 1'b1;
         end else begin
            death_cnt_d = death_cnt_q + 9'd1;
         end
      end
   end

   // Outputs
   always_comb begin
      freezeMove   = (state_q != S_PLAY);
      invulnerable = (invuln_cnt_q != 9'd0);
      hitOut       = qual_hit;
      respawnReq   = respawn_req_q;
      lives        = lives_q;
      level        = level_q;
      gameState    = state_q;
      deathPhase   = death_cnt_q[7:6];
   end

endmodule
